// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared definitions for the RAM arbiter slice: default bus widths, the
//   arbitration FSM encoding, the read-owner codes that steer read data back
//   to the CPU or the DMA port, and the counter-width helper for the
//   starvation timer.
package ram_arbiter_pkg;

  localparam int unsigned DefAddrW       = 16;
  localparam int unsigned DefDataW       = 8;
  localparam int unsigned DefStarveLimit = 32;

  // Arbitration FSM. Encodings are fixed so they line up with the rest of
  // the ram bus code.
  typedef enum logic [1:0] {
    StNormal = 2'd0,
    StHold   = 2'd1,
    StForce  = 2'd2
  } arb_state_e;

  // Which requester issued the RAM access (or the last read).
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnCpu  = 2'd1,
    OwnDma  = 2'd2
  } rd_owner_e;

  // Width of a counter that must reach `limit` (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ram_arbiter_starve_timer.sv
// starve_timer
//   Saturating counter of consecutive cycles in which a DMA request waits
//   without being served. `expired` is combinational and goes high in the
//   cycle whose edge brings the count up to LIMIT, so the caller can react
//   on that same edge. LIMIT = 0 disables the timer entirely.
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous, active-high
//   pend     in   a request is waiting this cycle
//   clr      in   clear the count (takes priority over pend)
//   expired  out  count reaches LIMIT at the end of this cycle
module starve_timer
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = DefStarveLimit
) (
  input  logic clock,
  input  logic reset,
  input  logic pend,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CntW = cnt_width(LIMIT);
  localparam logic [CntW-1:0] CntMax  = CntW'(LIMIT);
  localparam logic [CntW-1:0] CntLast = CntW'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (pend && (count_q != CntMax)) begin
      count_q <= count_q + CntW'(1);
    end
  end

  // Once saturated the flag stays up for as long as the request keeps waiting.
  assign expired = (LIMIT != 0) && pend && !clr && (count_q >= CntLast);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port synchronous RAM (1-cycle read latency) between
//   the CPU core and a DMA/loader port. The CPU has fixed priority and its
//   strobes reach the RAM combinationally. DMA is served in cycles with no
//   CPU access; if a DMA request waits STARVE_LIMIT cycles, cpu_hold is
//   raised to freeze the core and the DMA access is forced through.
// Ports
//   clock, reset                     clock / async active-high reset
//   cpu_rd, cpu_wr, cpu_a, cpu_d     CPU strobes, address, write data
//   cpu_q                            data of the CPU's most recent read
//   cpu_hold                         registered core freeze request
//   dma_req, dma_we, dma_a,
//   dma_wdata                        DMA request (held until dma_ack)
//   dma_ack                          combinational: DMA access issued now
//   dma_rdata, dma_rvalid            DMA read data, valid one cycle after ack
//   ram_rd, ram_wr, ram_a, ram_d     RAM strobes, address, write data
//   ram_q                            RAM read data (cycle after ram_rd)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
  input  logic              clock,
  input  logic              reset,
  // CPU side
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_d,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_hold,
  // DMA side
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_a,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  // RAM side
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  arb_state_e        state_q;
  logic              cpu_hold_q;
  rd_owner_e         last_rd_q;
  logic              dma_rvalid_q;
  logic [DATA_W-1:0] cpu_q_hold_q;

  rd_owner_e         grant;
  logic              cpu_act;
  logic              pend;
  logic              expired;

  // In FORCE the core is frozen and its strobes are ignored.
  assign cpu_act = (cpu_rd || cpu_wr) && (state_q != StForce);

  // ---------------------------------------------------------------------
  // Arbitration and RAM steering
  // ---------------------------------------------------------------------
  always_comb begin
    grant   = OwnNone;
    ram_rd  = 1'b0;
    ram_wr  = 1'b0;
    ram_a   = cpu_a;
    ram_d   = cpu_d;
    dma_ack = 1'b0;
    // Nothing is issued while reset is applied, so a pending DMA request
    // cannot be acknowledged into a design that is being cleared.
    if (!reset) begin
      if (cpu_act) begin
        grant  = OwnCpu;
        ram_wr = cpu_wr;
        // A simultaneous read and write is treated as a write.
        ram_rd = cpu_rd && !cpu_wr;
      end else if (dma_req) begin
        grant   = OwnDma;
        dma_ack = 1'b1;
        ram_a   = dma_a;
        ram_d   = dma_wdata;
        ram_wr  = dma_we;
        ram_rd  = !dma_we;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Starvation timer: counts waiting cycles, clears on ack or idle request
  // ---------------------------------------------------------------------
  assign pend = dma_req && !dma_ack;

  starve_timer #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_timer (
    .clock   (clock),
    .reset   (reset),
    .pend    (pend),
    .clr     (!pend),
    .expired (expired)
  );

  // ---------------------------------------------------------------------
  // Hold FSM with registered cpu_hold
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StNormal;
      cpu_hold_q <= 1'b0;
    end else begin
      unique case (state_q)
        StNormal: begin
          if (expired) begin
            state_q    <= StHold;
            cpu_hold_q <= 1'b1;
          end
        end
        StHold: begin
          // The core may still finish one access while the hold takes
          // effect; if that left no room for DMA, force it next cycle.
          if (dma_ack) begin
            state_q    <= StNormal;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q    <= StForce;
            cpu_hold_q <= 1'b1;
          end
        end
        StForce: begin
          state_q    <= StNormal;
          cpu_hold_q <= 1'b0;
        end
        default: begin
          state_q    <= StNormal;
          cpu_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_hold = cpu_hold_q;

  // ---------------------------------------------------------------------
  // Read-data routing
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_rd_q    <= OwnNone;
      dma_rvalid_q <= 1'b0;
      cpu_q_hold_q <= '0;
    end else begin
      last_rd_q    <= ram_rd ? grant : OwnNone;
      dma_rvalid_q <= ram_rd && (grant == OwnDma);
      if (last_rd_q == OwnCpu) begin
        cpu_q_hold_q <= ram_q;
      end
    end
  end

  // The CPU sees live RAM data only right after its own read; at all other
  // times it sees its captured copy, so DMA reads never disturb it.
  assign cpu_q      = (last_rd_q == OwnCpu) ? ram_q : cpu_q_hold_q;
  assign dma_rdata  = ram_q;
  assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned Limit = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_d;
  logic [DW-1:0] cpu_q;
  logic          cpu_hold;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_a;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          ram_rd, ram_wr;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q = '0;

  always #5 clock = ~clock;

  ram_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (Limit)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_a      (cpu_a),
    .cpu_d      (cpu_d),
    .cpu_q      (cpu_q),
    .cpu_hold   (cpu_hold),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_a      (dma_a),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .ram_rd     (ram_rd),
    .ram_wr     (ram_wr),
    .ram_a      (ram_a),
    .ram_d      (ram_d),
    .ram_q      (ram_q)
  );

  // Single-port RAM, one cycle read latency.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clock) begin
    if (ram_wr) mem[ram_a] <= ram_d;
    if (ram_rd) ram_q <= mem[ram_a];
  end

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  logic [DW-1:0] shadow [bit [15:0]];
  logic [DW-1:0] exp_cpu [$];
  logic [DW-1:0] exp_dma [$];
  logic [DW-1:0] cpu_q_model = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and score the registered outputs of the cycle just ended.
  task automatic step();
    @(posedge clock);
    #1;
    if (exp_cpu.size() != 0) cpu_q_model = exp_cpu.pop_front();
    check_eq("cpu_q", 32'(cpu_q), 32'(cpu_q_model));
    if (exp_dma.size() != 0) begin
      check_eq("dma_rvalid", 32'(dma_rvalid), 32'd1);
      check_eq("dma_rdata", 32'(dma_rdata), 32'(exp_dma.pop_front()));
    end else begin
      check_eq("dma_rvalid_idle", 32'(dma_rvalid), 32'd0);
    end
  endtask

  // One cycle in which the CPU is expected to own the RAM.
  task automatic cpu_cycle(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [7:0] d, input logic hold_exp);
    cpu_rd = rd;
    cpu_wr = wr;
    cpu_a  = a;
    cpu_d  = d;
    #1;
    check_eq("cpu_ram_rd", 32'(ram_rd), 32'(rd && !wr));
    check_eq("cpu_ram_wr", 32'(ram_wr), 32'(wr));
    check_eq("cpu_ram_a", 32'(ram_a), 32'(a));
    if (wr) check_eq("cpu_ram_d", 32'(ram_d), 32'(d));
    check_eq("cpu_dma_ack", 32'(dma_ack), 32'd0);
    check_eq("cpu_hold", 32'(cpu_hold), 32'(hold_exp));
    if (wr) shadow[a] = d;
    else if (rd) exp_cpu.push_back(shadow[a]);
    step();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  // One cycle in which the DMA access is expected to be acknowledged.
  task automatic dma_cycle(input logic we, input logic [15:0] a, input logic [7:0] d,
                           input logic hold_exp);
    dma_req   = 1'b1;
    dma_we    = we;
    dma_a     = a;
    dma_wdata = d;
    #1;
    check_eq("dma_ack", 32'(dma_ack), 32'd1);
    check_eq("dma_ram_a", 32'(ram_a), 32'(a));
    check_eq("dma_ram_wr", 32'(ram_wr), 32'(we));
    check_eq("dma_ram_rd", 32'(ram_rd), 32'(!we));
    if (we) check_eq("dma_ram_d", 32'(ram_d), 32'(d));
    check_eq("dma_hold", 32'(cpu_hold), 32'(hold_exp));
    if (we) shadow[a] = d;
    else exp_dma.push_back(shadow[a]);
    step();
    dma_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    reset = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = '0; cpu_d = '0;
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 16'h0010; dma_wdata = '0;

    // Reset state, with a DMA request present that must not be acked.
    #1;
    check_eq("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check_eq("rst_dma_ack", 32'(dma_ack), 32'd0);
    check_eq("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    check_eq("rst_cpu_q", 32'(cpu_q), 32'd0);
    check_eq("rst_ram_rd", 32'(ram_rd), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    dma_req = 1'b0;
    reset   = 1'b0;

    // 1. CPU only: load 7B 7A 30 00 (last as a combined rd+wr), then read loop.
    cpu_cycle(1'b0, 1'b1, 16'h0000, 8'h7B, 1'b0);
    cpu_cycle(1'b0, 1'b1, 16'h0001, 8'h7A, 1'b0);
    cpu_cycle(1'b0, 1'b1, 16'h0002, 8'h30, 1'b0);
    cpu_cycle(1'b1, 1'b1, 16'h0003, 8'h00, 1'b0);
    for (int r = 0; r < 8; r++) cpu_cycle(1'b1, 1'b0, 16'(r % 4), 8'h00, 1'b0);

    // 2. Idle-cycle DMA write then back-to-back read of the same address.
    dma_cycle(1'b1, 16'h0010, 8'h5A, 1'b0);
    dma_cycle(1'b0, 16'h0010, 8'h00, 1'b0);

    // 3. Contention: CPU read wins, DMA served in the next idle cycle.
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 16'h0002;
    cpu_cycle(1'b1, 1'b0, 16'h0001, 8'h00, 1'b0);
    dma_cycle(1'b0, 16'h0002, 8'h00, 1'b0);

    // 4. DMA read must not disturb the CPU's read data.
    cpu_cycle(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    dma_cycle(1'b0, 16'h0001, 8'h00, 1'b0);
    step();

    // 5. Starvation: a dropped request restarts the count; then 4 waits -> hold.
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 16'h0003;
    for (int k = 0; k < 3; k++) cpu_cycle(1'b1, 1'b0, 16'(k), 8'h00, 1'b0);
    dma_req = 1'b0;
    cpu_cycle(1'b1, 1'b0, 16'h0003, 8'h00, 1'b0);
    dma_req = 1'b1;
    for (int k = 0; k < 4; k++) cpu_cycle(1'b1, 1'b0, 16'(k), 8'h00, 1'b0);
    cpu_cycle(1'b1, 1'b0, 16'h0001, 8'h00, 1'b1);   // HOLD: core access completes
    cpu_rd = 1'b1; cpu_a = 16'h0002;                // FORCE: strobe ignored
    dma_cycle(1'b0, 16'h0003, 8'h00, 1'b1);
    cpu_rd = 1'b0;
    check_eq("hold_released", 32'(cpu_hold), 32'd0);
    step();

    // 6a. Reset while a DMA read result is being presented.
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 16'h0010;
    #1;
    check_eq("pre_rst_ack", 32'(dma_ack), 32'd1);
    @(posedge clock);
    #1;
    dma_req = 1'b0;
    check_eq("pre_rst_rvalid", 32'(dma_rvalid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_rvalid_drop", 32'(dma_rvalid), 32'd0);
    check_eq("rst_cpu_q_clear", 32'(cpu_q), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cpu_q_model = '0;

    // 6b. Reset during HOLD with a DMA read pending.
    dma_req = 1'b1; dma_we = 1'b0; dma_a = 16'h0002;
    for (int k = 0; k < 4; k++) cpu_cycle(1'b1, 1'b0, 16'(k), 8'h00, 1'b0);
    check_eq("hold_entered", 32'(cpu_hold), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_hold_drop", 32'(cpu_hold), 32'd0);
    check_eq("rst_ack_drop", 32'(dma_ack), 32'd0);
    check_eq("rst_rvalid_low", 32'(dma_rvalid), 32'd0);
    check_eq("rst_ram_rd_low", 32'(ram_rd), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cpu_q_model = '0;
    exp_cpu.delete();
    dma_cycle(1'b0, 16'h0002, 8'h00, 1'b0);        // NORMAL: acked in idle cycle
    step();

    check_eq("cpu_queue_drained", 32'(exp_cpu.size()), 32'd0);
    check_eq("dma_queue_drained", 32'(exp_dma.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
